// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared cpu package with hazard FSM encoding, counter width and saturating increment
package hazard_ctrl_pkg;
  localparam int CNT_W = 16;
  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use match of the ID sources against the EX load destination
// ports: id_rs1_addr/id_rs2_addr, id_rs1_used/id_rs2_used, ex_rd_addr, ex_mem_read in; hit out
module hazard_cmp (
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_mem_read,
  output logic       hit
);
  always_comb hit = ex_mem_read && ex_rd_addr != 5'd0 &&
                    ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
                     (id_rs2_used && id_rs2_addr == ex_rd_addr));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with MDU wait FSM and saturating stall/flush counters
// in:  clk, reset (async, active-high), ID sources, EX load/branch/MDU status, dmem_ready
// out: pc_en, per-stage valid/flush enables, stall_cnt, flush_cnt, mdu_busy
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_valid,
  output logic             if_id_flush,
  output logic             id_ex_valid,
  output logic             id_ex_flush,
  output logic             ex_mem_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mdu_busy
);
  state_t state;
  logic hit, run, mdu_stall, go, lu;
  hazard_cmp u_cmp (
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd_addr (ex_rd_addr),
    .ex_mem_read(ex_mem_read),
    .hit        (hit)
  );
  // go: no reset, MEM stall or MDU stall; branch beats load-use below it
  always_comb begin
    run = state == RUN;
    mdu_stall = run ? ex_mdu_start : !mdu_done;
    go = !reset && dmem_ready && !mdu_stall;
    lu = run && hit && !ex_branch_taken;
    pc_en = go && !lu;
    if_id_valid = pc_en;
    id_ex_valid = go;
    ex_mem_valid = go;
    if_id_flush = go && run && ex_branch_taken;
    id_ex_flush = go && run && (ex_branch_taken || hit);
    mdu_busy = state == MDU_WAIT;
  end
  // a done pulse during a MEM stall is dropped, so the FSM only moves when dmem_ready
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (dmem_ready) state <= run ? (ex_mdu_start ? MDU_WAIT : RUN) : (mdu_done ? RUN : MDU_WAIT);
      if (!pc_en) stall_cnt <= sat_inc(stall_cnt);
      if (if_id_flush) flush_cnt <= sat_inc(flush_cnt);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with a rule-level reference model
module tb_hazard_ctrl;
  logic clk = 0, reset = 0;
  logic [4:0] id_rs1_addr = 0, id_rs2_addr = 0, ex_rd_addr = 0;
  logic id_rs1_used = 0, id_rs2_used = 0, ex_mem_read = 0, ex_branch_taken = 0;
  logic ex_mdu_start = 0, mdu_done = 0, dmem_ready = 1;
  logic pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush, ex_mem_valid, mdu_busy;
  logic [15:0] stall_cnt, flush_cnt;
  typedef struct packed {
    logic pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush, ex_mem_valid, mdu_busy;
    logic [15:0] stall_cnt, flush_cnt;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  bit waiting = 0;
  int stalls = 0, flushes = 0;
  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_valid(if_id_valid), .if_id_flush(if_id_flush),
    .id_ex_valid(id_ex_valid), .id_ex_flush(id_ex_flush), .ex_mem_valid(ex_mem_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mdu_busy(mdu_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
    if (a !== x) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (vector %0d)", n, a, x, vectors);
    end
  endtask
  // one cycle: drive at negedge, predict the outputs from the stated rules, then advance the model
  task automatic cyc(input bit rst, input bit rdy, input bit st, input bit dn, input bit br,
                     input bit mr, input bit u1, input bit u2,
                     input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    bit hit;
    @(negedge clk);
    reset = rst; dmem_ready = rdy; ex_mdu_start = st; mdu_done = dn; ex_branch_taken = br;
    ex_mem_read = mr; id_rs1_used = u1; id_rs2_used = u2;
    ex_rd_addr = rd; id_rs1_addr = r1; id_rs2_addr = r2;
    hit = mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    if (rst) begin waiting = 0; stalls = 0; flushes = 0; end
    e = '0;
    e.mdu_busy = waiting;
    e.stall_cnt = 16'(stalls);
    e.flush_cnt = 16'(flushes);
    if (!rst && rdy && !(waiting ? !dn : st)) begin
      e.pc_en = 1; e.if_id_valid = 1; e.id_ex_valid = 1; e.ex_mem_valid = 1;
      if (!waiting && br) begin
        e.if_id_flush = 1; e.id_ex_flush = 1;
      end else if (!waiting && hit) begin
        e.pc_en = 0; e.if_id_valid = 0; e.id_ex_flush = 1;
      end
    end
    q.push_back(e);
    if (!rst) begin
      if (!e.pc_en) stalls = stalls < 65535 ? stalls + 1 : 65535;
      if (e.if_id_flush) flushes = flushes < 65535 ? flushes + 1 : 65535;
      if (rdy) waiting = waiting ? !dn : st;
    end
  endtask
  task automatic idle(input bit rdy, input bit st, input bit dn);
    cyc(0, rdy, st, dn, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      chk("pc_en", 16'(pc_en), 16'(e.pc_en));
      chk("if_id_flush", 16'(if_id_flush), 16'(e.if_id_flush));
      chk("id_ex_flush", 16'(id_ex_flush), 16'(e.id_ex_flush));
      if (!e.if_id_flush) chk("if_id_valid", 16'(if_id_valid), 16'(e.if_id_valid));
      if (!e.id_ex_flush) chk("id_ex_valid", 16'(id_ex_valid), 16'(e.id_ex_valid));
      chk("ex_mem_valid", 16'(ex_mem_valid), 16'(e.ex_mem_valid));
      chk("mdu_busy", 16'(mdu_busy), 16'(e.mdu_busy));
      chk("stall_cnt", stall_cnt, e.stall_cnt);
      chk("flush_cnt", flush_cnt, e.flush_cnt);
    end
  end
  initial begin
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 1, 0, 5, 5, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 5, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 7, 3, 7);
    cyc(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 1, 1, 0, 5, 5, 0);
    idle(1, 1, 0);
    repeat (3) idle(1, 0, 0);
    idle(1, 0, 1);
    idle(1, 0, 0);
    idle(1, 1, 0);
    idle(1, 0, 0);
    repeat (2) idle(0, 0, 1);
    idle(1, 0, 0);
    idle(1, 0, 1);
    idle(1, 0, 0);
    idle(1, 1, 0);
    idle(1, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 1);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (2000)
      cyc($urandom_range(127) == 0, $urandom_range(7) != 0, $urandom_range(7) == 0,
          $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
          $urandom_range(1) == 1, $urandom_range(1) == 1,
          5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0);
    #3;
    force dut.stall_cnt = 16'hFFFF;
    stalls = 65535;
    idle(0, 0, 0);
    idle(0, 0, 0);
    #3;
    release dut.stall_cnt;
    repeat (3) idle(0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 1, 0, 9, 9, 0);
    idle(1, 0, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide clk, input, 1, pipeline clock; all state updates on posedge clk.
REQ-002 SHALL provide reset, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL provide id_rs1_addr / id_rs2_addr, input, 5 each, source register addresses of the instruction in ID.
REQ-004 SHALL provide id_rs1_used / id_rs2_used, input, 1 each, ID instruction actually reads rs1 / rs2.
REQ-005 SHALL provide ex_rd_addr, input, 5, destination address held in the ID/EX register.
REQ-006 SHALL provide ex_mem_read, input, 1, the EX instruction is a load.
REQ-007 SHALL provide ex_branch_taken, input, 1, the EX instruction redirects the PC this cycle.
REQ-008 SHALL provide ex_mdu_start / mdu_done, input, 1 each, multi-cycle mul/div launch and one-cycle completion pulse.
REQ-009 SHALL provide dmem_ready, input, 1, data memory accepts or returns this cycle.
REQ-010 SHALL provide pc_en, output, 1, PC register load enable.
REQ-011 SHALL provide if_id_valid / if_id_flush, output, 1 each, IF/ID register load enable and clear.
REQ-012 SHALL provide id_ex_valid / id_ex_flush, output, 1 each, ID/EX register load enable and clear.
REQ-013 SHALL provide ex_mem_valid, output, 1, EX/MEM register load enable.
REQ-014 SHALL provide stall_cnt / flush_cnt, output, 16 each, saturating event counters.
REQ-015 SHALL provide mdu_busy, output, 1, high while the FSM is in MDU_WAIT.

Function
REQ-016 SHALL implement a two-state FSM (RUN, MDU_WAIT); all control outputs are Mealy, derived from state and current inputs.
REQ-017 SHALL default in RUN, with no condition present, to pc_en=1, all *_valid=1, all *_flush=0.
REQ-018 SHALL apply conditions in this priority: MEM stall > MDU stall > branch flush > load-use stall.
REQ-019 MEM stall (dmem_ready=0, any state): pc_en=0, all *_valid=0, all *_flush=0; FSM state and counters other than stall_cnt hold.
REQ-020 Entering MDU (RUN and ex_mdu_start=1): next state MDU_WAIT; pc_en, if_id_valid, id_ex_valid, ex_mem_valid all 0 in the start cycle.
REQ-021 In MDU_WAIT with mdu_done=0, outputs SHALL be the same as in REQ-020.
REQ-022 In MDU_WAIT with mdu_done=1 and dmem_ready=1: default outputs; next state RUN. A done pulse coincident with a MEM stall SHALL be ignored, and state SHALL stay MDU_WAIT.
REQ-023 Branch flush (RUN, ex_branch_taken=1, no higher condition): pc_en=1, if_id_flush=1, id_ex_flush=1, valids=1.
REQ-024 Load-use hit = ex_mem_read & ex_rd_addr!=0 & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
REQ-025 Load-use stall (RUN, hit, no higher condition): pc_en=0, if_id_valid=0, id_ex_flush=1, ex_mem_valid=1; lasts exactly one cycle because the bubble clears ex_mem_read.
REQ-026 Flush SHALL take precedence over valid at the pipeline register: any *_flush=1 implies the same stage's *_valid is don't-care.
REQ-027 stall_cnt SHALL increment by 1 on each cycle in which pc_en=0; flush_cnt SHALL increment by 1 on each cycle in which if_id_flush=1; both saturate at 16'hFFFF with no wrap.
REQ-028 mdu_busy SHALL be registered-state based (state==MDU_WAIT) and free of input glitches.

Reset
REQ-029 While reset=1: state=RUN, stall_cnt=0, flush_cnt=0, mdu_busy=0, pc_en=0, all *_valid=0, all *_flush=0.
REQ-030 Reset asserted in MDU_WAIT SHALL abandon the wait immediately; the first cycle after release SHALL behave as RUN.

Structure
REQ-031 The FSM state encoding (RUN=0, MDU_WAIT=1) and the counter width constant (16) SHALL reside in the shared cpu package.
REQ-032 Load-use matching SHALL be a combinational sub-module, hazard_cmp, with inputs from REQ-024 and output hit.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs1_addr=5, id_rs1_used=1 -> one cycle of pc_en=0, id_ex_flush=1, stall_cnt +1.
REQ-034 Branch with simultaneous load-use hit -> if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cnt unchanged, flush_cnt +1.
REQ-035 ex_mdu_start, then mdu_done on the 4th following cycle -> 4 stall cycles, mdu_busy high for 4 cycles, RUN on the cycle after done.
REQ-036 dmem_ready=0 for 2 cycles overlapping mdu_done -> all valids 0, state stays MDU_WAIT; a later done releases it.
REQ-037 Reset pulse while in MDU_WAIT -> all outputs 0 during reset; RUN defaults afterwards with counters at 0.
REQ-038 Force stall_cnt to 16'hFFFF, then stall -> value stays 16'hFFFF.
